// File: rtl/serial_add_pkg.sv
// Purpose : shared types and sizing helpers for the bit-serial adder.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// Contents:
//   state_e    - FSM encoding shared by the adder and anything that observes it
//   cnt_width  - bit-counter width for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Counter must index bits 0..WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_unit_if.sv
// Purpose : operand-in / result-out handshake bundle for serial_add_unit.
// Latency : n/a (wires only).
// Backpressure : in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready, a, b, cin   - operand handshake
//   out_valid, out_ready, sum, cout - result handshake
//   busy                            - adder is stepping through bits
// Modports: master = upstream/downstream environment, slave = the adder.
interface serial_add_unit_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_add_unit_fa_cell.sv
// Purpose : single-bit combinational full adder.
// Latency : 0 cycles (combinational).
// Backpressure : none.
//
// Ports:
//   a_i, b_i, cin_i - addend bits and carry-in
//   s_o, cout_o     - sum bit and carry-out (majority of inputs)
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_add_unit.sv
// Purpose : bit-serial adder, one bit pair per cycle LSB first through one full-adder cell.
// Latency : WIDTH cycles in ADD after acceptance; result presented until taken.
// Backpressure : in_ready low from acceptance until the result is taken; result held while out_ready low.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - serial_add_unit_if slave: operand handshake in, result handshake out, busy
// WIDTH must match the width of the connected interface instance (2..32).
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_unit_if.slave   bus
);

  localparam int unsigned          CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  // The only arithmetic in the block: one bit per cycle from the low ends of SA/SB.
  fa_cell u_fa (
    .a_i   (sa_q[0]),
    .b_i   (sb_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          carry_d = bus.cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at sum[0].
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
        end
      end

      DONE: begin
        // sum/cout are untouched here, so they stay stable under backpressure.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ADD);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_unit.sv
module tb_serial_add_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_add_unit_if #(.WIDTH(4)) bus4 ();
  serial_add_unit_if #(.WIDTH(8)) bus8 ();

  serial_add_unit #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  serial_add_unit #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus4.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b0;
  endtask

  // Offers one operand set to the 4-bit unit and returns the number of clock
  // edges from the accepting edge (counted as 1) until out_valid is seen.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv, output int lat);
    int guard;
    guard = 0;
    while (bus4.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    bus4.a        = av;
    bus4.b        = bv;
    bus4.cin      = cv;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 1;
    while (bus4.out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++; if (bus4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready); end
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
    n_checks++; if (bus4.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus4.busy); end
    n_checks++; if (bus4.sum !== 4'h0)       begin n_fail++; $display("FAIL reset_sum: got %h want 0", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus4.cout); end
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset8_out_valid: got %b want 0", bus8.out_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus4.out_ready = 1'b1;
    bus4.a = 4'h3; bus4.b = 4'h5; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus4.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_add[%0d]: got %b want 0", i, bus4.in_ready); end
      n_checks++; if (bus4.busy !== 1'b1)     begin n_fail++; $display("FAIL basic_busy[%0d]: got %b want 1", i, bus4.busy); end
      n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, bus4.out_valid); end
      tick();
    end
    n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", bus4.out_valid); end
    n_checks++; if (bus4.in_ready !== 1'b0)  begin n_fail++; $display("FAIL basic_in_ready_done: got %b want 0", bus4.in_ready); end
    n_checks++; if (bus4.sum !== 4'h8)       begin n_fail++; $display("FAIL basic_sum: got %h want 8", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b0)      begin n_fail++; $display("FAIL basic_cout: got %b want 0", bus4.cout); end
    tick();
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", bus4.out_valid); end
    n_checks++; if (bus4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL basic_back_idle: got %b want 1", bus4.in_ready); end
  endtask

  task automatic test_carry_chain();
    int lat;
    bus4.out_ready = 1'b1;
    run4(4'hF, 4'h0, 1'b1, lat);
    n_checks++; if (lat != 5)           begin n_fail++; $display("FAIL carry1_latency: got %0d want 5", lat); end
    n_checks++; if (bus4.sum !== 4'h0)  begin n_fail++; $display("FAIL carry1_sum: got %h want 0", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b1) begin n_fail++; $display("FAIL carry1_cout: got %b want 1", bus4.cout); end
    tick();
    run4(4'hF, 4'hF, 1'b1, lat);
    n_checks++; if (bus4.sum !== 4'hF)  begin n_fail++; $display("FAIL carry2_sum: got %h want f", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b1) begin n_fail++; $display("FAIL carry2_cout: got %b want 1", bus4.cout); end
    tick();
    run4(4'h0, 4'h0, 1'b0, lat);
    n_checks++; if (bus4.sum !== 4'h0)  begin n_fail++; $display("FAIL zero_sum: got %h want 0", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b0) begin n_fail++; $display("FAIL zero_cout: got %b want 0", bus4.cout); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bus4.out_ready = 1'b0;
    run4(4'h9, 4'h9, 1'b0, lat);
    n_checks++; if (lat != 5)           begin n_fail++; $display("FAIL bp_latency: got %0d want 5", lat); end
    n_checks++; if (bus4.sum !== 4'h2)  begin n_fail++; $display("FAIL bp_sum: got %h want 2", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b1) begin n_fail++; $display("FAIL bp_cout: got %b want 1", bus4.cout); end
    for (int i = 0; i < 6; i++) begin
      bus4.in_valid = (i % 2 == 0);
      bus4.a = 4'h7; bus4.b = 4'h1; bus4.cin = 1'b1;
      tick();
      n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus4.out_valid); end
      n_checks++; if (bus4.sum !== 4'h2)       begin n_fail++; $display("FAIL bp_hold_sum[%0d]: got %h want 2", i, bus4.sum); end
      n_checks++; if (bus4.cout !== 1'b1)      begin n_fail++; $display("FAIL bp_hold_cout[%0d]: got %b want 1", i, bus4.cout); end
      n_checks++; if (bus4.in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus4.in_ready); end
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus4.out_valid); end
    n_checks++; if (bus4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_idle: got %b want 1", bus4.in_ready); end
  endtask

  task automatic test_async_reset();
    int lat;
    bus4.out_ready = 1'b1;
    bus4.a = 4'hF; bus4.b = 4'h0; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b want 0", bus4.out_valid); end
    n_checks++; if (bus4.busy !== 1'b0)      begin n_fail++; $display("FAIL areset_busy: got %b want 0", bus4.busy); end
    n_checks++; if (bus4.sum !== 4'h0)       begin n_fail++; $display("FAIL areset_sum: got %h want 0", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b0)      begin n_fail++; $display("FAIL areset_cout: got %b want 0", bus4.cout); end
    n_checks++; if (bus4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", bus4.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run4(4'h1, 4'h1, 1'b0, lat);
    n_checks++; if (lat != 5)           begin n_fail++; $display("FAIL areset_after_latency: got %0d want 5", lat); end
    n_checks++; if (bus4.sum !== 4'h2)  begin n_fail++; $display("FAIL areset_after_sum: got %h want 2", bus4.sum); end
    n_checks++; if (bus4.cout !== 1'b0) begin n_fail++; $display("FAIL areset_after_cout: got %b want 0", bus4.cout); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [16];
    logic [3:0] bv [16];
    logic       cv [16];
    logic [4:0] ev [16];
    logic [4:0] got;
    logic       acc;
    logic       oh;
    int acc_i, out_i, cyc, last_acc;
    for (int i = 0; i < 16; i++) begin
      av[i] = 4'($urandom_range(0, 15));
      bv[i] = 4'($urandom_range(0, 15));
      cv[i] = 1'($urandom_range(0, 1));
      ev[i] = {1'b0, av[i]} + {1'b0, bv[i]} + {4'b0, cv[i]};
    end
    acc_i = 0; out_i = 0; cyc = 0; last_acc = -1;
    bus4.out_ready = 1'b1;
    bus4.a = av[0]; bus4.b = bv[0]; bus4.cin = cv[0]; bus4.in_valid = 1'b1;
    while (out_i < 16 && cyc < 2000) begin
      acc = bus4.in_valid & bus4.in_ready;
      oh  = bus4.out_valid & bus4.out_ready;
      if (oh) begin
        got = {bus4.cout, bus4.sum};
        n_checks++; if (got !== ev[out_i]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", out_i, got, ev[out_i]); end
        out_i++;
      end
      if (acc) begin
        if (last_acc >= 0) begin
          n_checks++; if (cyc - last_acc != 6) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 6", acc_i, cyc - last_acc); end
        end
        last_acc = cyc;
        acc_i++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (acc_i < 16) begin
          bus4.a = av[acc_i]; bus4.b = bv[acc_i]; bus4.cin = cv[acc_i];
        end else begin
          bus4.in_valid = 1'b0;
        end
      end
    end
    n_checks++; if (out_i != 16) begin n_fail++; $display("FAIL b2b_out_count: got %0d want 16", out_i); end
    n_checks++; if (acc_i != 16) begin n_fail++; $display("FAIL b2b_acc_count: got %0d want 16", acc_i); end
    bus4.in_valid = 1'b0;
    tick();
    n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", bus4.out_valid); end
  endtask

  task automatic test_width8();
    int lat;
    int guard;
    guard = 0;
    bus8.out_ready = 1'b1;
    while (bus8.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    lat = 1;
    while (bus8.out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    n_checks++; if (lat != 9)           begin n_fail++; $display("FAIL w8_latency: got %0d want 9", lat); end
    n_checks++; if (bus8.sum !== 8'h00) begin n_fail++; $display("FAIL w8_sum: got %h want 00", bus8.sum); end
    n_checks++; if (bus8.cout !== 1'b1) begin n_fail++; $display("FAIL w8_cout: got %b want 1", bus8.cout); end
    tick();
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL w8_valid_drop: got %b want 0", bus8.out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
